control_fsm: RTL and testbench
==============================

# control_fsm

Multicycle main controller plus instruction decode for the ARM-subset processor. It sits directly upstream of the conditional unit and drives its unconditioned strobes (PCS, RegW, MemW, FlagW). It also produces the per-cycle datapath selects (IR load, PC advance, address/ALU/result muxing, ALU operation, immediate/register-source selects). The sequencer is a registered Moore FSM stepping each instruction through fetch, decode, execute and writeback cycles.

## Interface
Parameters: none.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `Op`  in  2  instr[27:26] from the instruction register
- `Funct`  in  6  instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (L bit for memory ops)
- `Rd`  in  4  instr[15:12]
- `PCS`  out  1  PC-write request (branch or Rd==15 register write)
- `RegW`  out  1  register-file write request
- `MemW`  out  1  data-memory write request
- `FlagW`  out  2  [1]=N/Z update, [0]=C/V update
- `NextPC`  out  1  unconditional PC advance
- `IRWrite`  out  1  instruction-register load
- `AdrSrc`  out  1  0=PC, 1=ALU result
- `ALUSrcA`  out  1  0=Rn, 1=PC
- `ALUSrcB`  out  2  00=Rm, 01=ExtImm, 10=const 4
- `ResultSrc`  out  2  00=ALUOut, 01=ReadData, 10=ALUResult
- `ALUControl`  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- `ImmSrc`  out  2  equal to `Op`
- `RegSrc`  out  2  [0]=(Op==10), [1]=(Op==01)
- `Illegal`  out  1  present only with `CTRL_ILLEGAL_TRAP_EN`

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, plus TRAP when configured.
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op=01→MEMADR; Op=00 with I=0→EXECR; Op=00 with I=1→EXECI; Op=10→BRANCH; Op=11→illegal handling.
  - MEMADR: Funct[0]=1→MEMRD, else MEMWR.
  - MEMRD→MEMWB→FETCH. MEMWR→FETCH. EXECR/EXECI→ALUWB→FETCH. BRANCH→FETCH.
- Moore outputs per state. Any field not listed is 0.
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1 unless NoWrite.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode applies when ALUOp=1 (internal), keyed on cmd:
  - 0100 ADD→00
  - 0010 SUB→01
  - 0000 AND→10
  - 1100 ORR→11
  - 1010 CMP→01 with NoWrite=1
  - other cmd→00 with NoWrite=1
- Flag-update rules:
  - FlagW[1] = S.
  - FlagW[0] = S & (ALUControl ∈ {00,01}).
  - CMP forces FlagW=11 regardless of S.
- When ALUOp=0: ALUControl=00, FlagW=00, NoWrite=0.
- PCS = Branch | (RegW & Rd==4'hF).

## Timing
- Reset asserted (reset=0): state←FETCH immediately, without waiting for a clock edge. While reset is low, all strobes (PCS, RegW, MemW, FlagW, NextPC, IRWrite, Illegal) are forced to 0. Selects take their FETCH values.
- First rising edge after reset deasserts: FETCH is active with strobes live.
- The state register updates on the rising edge. Outputs are combinational from state and the instruction fields. Op/Funct/Rd must be stable from DECODE onward, since IR loads at the end of FETCH.
- Cycles per instruction: LDR 5, STR 4, data-processing 4, B 3.
- Reset mid-instruction: the partial instruction is abandoned and no further RegW/MemW is issued.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - DECODE with Op=11 goes to TRAP.
  - TRAP holds until reset, with `Illegal`=1 and all other strobes 0.
- `CTRL_ILLEGAL_TRAP_EN` undefined:
  - DECODE with Op=11 returns to FETCH, so the instruction acts as a 2-cycle NOP.
  - The `Illegal` port does not exist.

## Test plan
- Hold reset=0 for 3 cycles → IRWrite=0, NextPC=0, RegW=0. Release reset → IRWrite=1 and NextPC=1 on the first cycle.
- LDR (Op=01, Funct=011001, Rd=3) → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. RegW=1 only in cycle 5, with ResultSrc=01. PCS=0.
- STR (Op=01, Funct=011000) → MemW=1 with AdrSrc=1 in cycle 4. The next cycle is FETCH.
- ADDS R15 (Op=00, Funct=101001, Rd=15) → EXECI with ALUControl=00 and FlagW=11. ALUWB with RegW=1 and PCS=1.
- CMP reg (Op=00, Funct=010101) → ALUControl=01 and FlagW=11 in EXECR. ALUWB with RegW=0.
- B (Op=10) → BRANCH on cycle 3 with PCS=1. Op=11 → TRAP with Illegal=1 if configured, otherwise FETCH on cycle 3.
- Reset pulse during MEMRD → state is FETCH immediately and no RegW is issued afterward.

Source files
------------

// File: rtl/control_fsm.sv
// control_fsm: multicycle main controller and instruction decoder for the ARM-subset core.
// Steps each instruction through fetch/decode/execute/writeback. Outputs are combinational
// from the state register and the instruction fields. Strobes are held low while reset is low.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN. When it is defined, Op=11 parks the sequencer
// in a trap state and the Illegal output is present.
module control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       NextPC,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       Illegal
`endif
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
    StExecR, StExecI, StAluWb, StBranch, StTrap
  } state_e;

  state_e     state, state_next;
  logic       alu_op, branch;
  logic       reg_w_raw, mem_w_raw, next_pc_raw, ir_write_raw;
  logic [1:0] dec_ctrl;
  logic       no_write, is_cmp;
  logic       imm_bit, s_bit;
  logic [3:0] cmd;

  assign imm_bit = Funct[5];
  assign cmd     = Funct[4:1];
  assign s_bit   = Funct[0];

  // State register; asserting reset drops straight back to fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= StFetch;
    else        state <= state_next;
  end

  // Sequencing between instruction phases.
  always_comb begin
    state_next = StFetch;
    case (state)
      StFetch:  state_next = StDecode;
      StDecode: begin
        case (Op)
          2'b01:   state_next = StMemAdr;
          2'b00:   state_next = imm_bit ? StExecI : StExecR;
          2'b10:   state_next = StBranch;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default: state_next = StTrap;
`else
          // Unsupported op class behaves as a two-cycle no-op.
          default: state_next = StFetch;
`endif
        endcase
      end
      StMemAdr: state_next = s_bit ? StMemRd : StMemWr;
      StMemRd:  state_next = StMemWb;
      StExecR:  state_next = StAluWb;
      StExecI:  state_next = StAluWb;
`ifdef CTRL_ILLEGAL_TRAP_EN
      StTrap:   state_next = StTrap;
`endif
      default:  state_next = StFetch;
    endcase
  end

  // Per-state Moore selects and raw (ungated) strobes.
  always_comb begin
    ir_write_raw = 1'b0;
    next_pc_raw  = 1'b0;
    AdrSrc       = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ResultSrc    = 2'b00;
    alu_op       = 1'b0;
    branch       = 1'b0;
    reg_w_raw    = 1'b0;
    mem_w_raw    = 1'b0;
    case (state)
      StFetch: begin
        ir_write_raw = 1'b1;
        next_pc_raw  = 1'b1;
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
      end
      StDecode: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StMemAdr: ALUSrcB = 2'b01;
      StMemRd:  AdrSrc  = 1'b1;
      StMemWb: begin
        ResultSrc = 2'b01;
        reg_w_raw = 1'b1;
      end
      StMemWr: begin
        AdrSrc    = 1'b1;
        mem_w_raw = 1'b1;
      end
      StExecR:  alu_op = 1'b1;
      StExecI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      // Writeback suppression comes from the command even though the ALU is idle here.
      StAluWb:  reg_w_raw = ~no_write;
      StBranch: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // Data-processing command decode.
  always_comb begin
    dec_ctrl = 2'b00;
    no_write = 1'b0;
    is_cmp   = 1'b0;
    case (cmd)
      4'b0100: dec_ctrl = 2'b00;
      4'b0010: dec_ctrl = 2'b01;
      4'b0000: dec_ctrl = 2'b10;
      4'b1100: dec_ctrl = 2'b11;
      4'b1010: begin
        dec_ctrl = 2'b01;
        no_write = 1'b1;
        is_cmp   = 1'b1;
      end
      default: no_write = 1'b1;
    endcase
  end

  assign ALUControl = alu_op ? dec_ctrl : 2'b00;
  // Carry/overflow only track arithmetic ops; compare always updates both groups.
  assign FlagW      = (reset && alu_op) ? (is_cmp ? 2'b11 : {s_bit, s_bit & ~dec_ctrl[1]})
                                        : 2'b00;
  assign RegW       = reset & reg_w_raw;
  assign MemW       = reset & mem_w_raw;
  assign NextPC     = reset & next_pc_raw;
  assign IRWrite    = reset & ir_write_raw;
  assign PCS        = reset & (branch | (reg_w_raw & (Rd == 4'hF)));
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign Illegal    = reset & (state == StTrap);
`endif

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed bench for control_fsm with a per-cycle expected-output scoreboard.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       pcs, reg_w, mem_w, next_pc, ir_write, adr_src, alu_src_a, illegal;
  logic [1:0] flag_w, alu_src_b, result_src, alu_ctrl, imm_src, reg_src;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (op),
    .Funct     (funct),
    .Rd        (rd),
    .PCS       (pcs),
    .RegW      (reg_w),
    .MemW      (mem_w),
    .FlagW     (flag_w),
    .NextPC    (next_pc),
    .IRWrite   (ir_write),
    .AdrSrc    (adr_src),
    .ALUSrcA   (alu_src_a),
    .ALUSrcB   (alu_src_b),
    .ResultSrc (result_src),
    .ALUControl(alu_ctrl),
    .ImmSrc    (imm_src),
    .RegSrc    (reg_src)
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    .Illegal   (illegal)
`endif
  );

`ifndef CTRL_ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

  typedef struct packed {
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic [1:0] flag_w;
    logic       next_pc;
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_ctrl;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic       illegal;
  } out_t;

  out_t exp_q[$];

  function automatic out_t snap();
    out_t r;
    r.pcs = pcs; r.reg_w = reg_w; r.mem_w = mem_w; r.flag_w = flag_w;
    r.next_pc = next_pc; r.ir_write = ir_write; r.adr_src = adr_src;
    r.alu_src_a = alu_src_a; r.alu_src_b = alu_src_b; r.result_src = result_src;
    r.alu_ctrl = alu_ctrl; r.imm_src = imm_src; r.reg_src = reg_src; r.illegal = illegal;
    return r;
  endfunction

  // Model: everything is zero except the op-derived selects.
  function automatic out_t base_row();
    out_t r = '0;
    r.imm_src = op;
    r.reg_src = {op == 2'b01, op == 2'b10};
    return r;
  endfunction

  function automatic out_t fetch_row();
    out_t r = base_row();
    r.ir_write = 1'b1; r.next_pc = 1'b1; r.alu_src_a = 1'b1;
    r.alu_src_b = 2'b10; r.result_src = 2'b10;
    return r;
  endfunction

  function automatic out_t reset_row();
    out_t r = fetch_row();
    r.ir_write = 1'b0; r.next_pc = 1'b0;
    return r;
  endfunction

  // Data-processing semantics: ALU op, flag groups updated, and whether Rd is written.
  task automatic alu_rule(input logic [3:0] c, input logic s, output logic [1:0] ctrl,
                          output logic [1:0] flags, output logic writes);
    writes = 1'b1;
    case (c)
      4'b0100: ctrl = 2'd0;
      4'b0010: ctrl = 2'd1;
      4'b0000: ctrl = 2'd2;
      4'b1100: ctrl = 2'd3;
      default: begin
        ctrl   = (c == 4'b1010) ? 2'd1 : 2'd0;
        writes = 1'b0;
      end
    endcase
    flags = (c == 4'b1010) ? 2'b11 : {s, s && (ctrl <= 2'd1)};
  endtask

  // Drive one instruction and queue at most 'limit' expected cycles.
  task automatic plan_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] d,
                            input int limit, output int n);
    out_t rows[$];
    out_t r;
    logic [1:0] c, fl;
    logic wr;
    op = o; funct = f; rd = d;
    rows.push_back(fetch_row());
    r = base_row(); r.alu_src_a = 1'b1; r.alu_src_b = 2'b10; r.result_src = 2'b10;
    rows.push_back(r);
    case (o)
      2'b01: begin
        r = base_row(); r.alu_src_b = 2'b01; rows.push_back(r);
        if (f[0]) begin
          r = base_row(); r.adr_src = 1'b1; rows.push_back(r);
          r = base_row(); r.result_src = 2'b01; r.reg_w = 1'b1; r.pcs = (d == 4'hF);
          rows.push_back(r);
        end else begin
          r = base_row(); r.adr_src = 1'b1; r.mem_w = 1'b1; rows.push_back(r);
        end
      end
      2'b00: begin
        alu_rule(f[4:1], f[0], c, fl, wr);
        r = base_row(); r.alu_src_b = f[5] ? 2'b01 : 2'b00; r.alu_ctrl = c; r.flag_w = fl;
        rows.push_back(r);
        r = base_row(); r.reg_w = wr; r.pcs = wr && (d == 4'hF); rows.push_back(r);
      end
      2'b10: begin
        r = base_row(); r.alu_src_b = 2'b01; r.result_src = 2'b10; r.pcs = 1'b1;
        rows.push_back(r);
      end
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        repeat (3) begin
          r = base_row(); r.illegal = 1'b1; rows.push_back(r);
        end
`endif
      end
    endcase
    n = 0;
    foreach (rows[i]) if (n < limit) begin
      exp_q.push_back(rows[i]);
      n++;
    end
  endtask

  task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] d);
    int n;
    plan_instr(o, f, d, 99, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pin(input string name, input logic [1:0] act, input logic [1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, want);
    end
  endtask

  // Compare every scheduled cycle on the falling edge.
  always @(negedge clk) begin
    out_t got, want;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = snap();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cycle_row t=%0t: got %h want %h", $time, got, want);
      end
    end
  end

  initial begin
    int n;
    reset = 1'b0; op = 2'b01; funct = 6'b011001; rd = 4'd3;
    @(posedge clk); #1;
    repeat (3) exp_q.push_back(reset_row());
    #2;
    pin("rst_irwrite", {1'b0, ir_write}, 2'b00);
    pin("rst_nextpc", {1'b0, next_pc}, 2'b00);
    pin("rst_regw", {1'b0, reg_w}, 2'b00);
    repeat (3) @(posedge clk);
    #1; reset = 1'b1;
    #1;
    pin("rel_irwrite", {1'b0, ir_write}, 2'b01);
    pin("rel_nextpc", {1'b0, next_pc}, 2'b01);

    // LDR R3
    plan_instr(2'b01, 6'b011001, 4'd3, 99, n);
    repeat (4) @(posedge clk);
    #2;
    pin("ldr_regw", {1'b0, reg_w}, 2'b01);
    pin("ldr_resultsrc", result_src, 2'b01);
    pin("ldr_pcs", {1'b0, pcs}, 2'b00);
    @(posedge clk); #1;

    // STR
    plan_instr(2'b01, 6'b011000, 4'd3, 99, n);
    repeat (3) @(posedge clk);
    #2;
    pin("str_memw", {1'b0, mem_w}, 2'b01);
    pin("str_adrsrc", {1'b0, adr_src}, 2'b01);
    @(posedge clk); #1;

    // ADDS R15, immediate
    plan_instr(2'b00, 6'b101001, 4'hF, 99, n);
    repeat (2) @(posedge clk);
    #2;
    pin("adds_aluctrl", alu_ctrl, 2'b00);
    pin("adds_flagw", flag_w, 2'b11);
    @(posedge clk); #2;
    pin("adds_regw", {1'b0, reg_w}, 2'b01);
    pin("adds_pcs", {1'b0, pcs}, 2'b01);
    @(posedge clk); #1;

    run_instr(2'b00, 6'b010101, 4'd2);   // CMP register
    run_instr(2'b00, 6'b100101, 4'd1);   // SUBS immediate
    run_instr(2'b00, 6'b000001, 4'd4);   // ANDS register
    run_instr(2'b00, 6'b011000, 4'hF);   // ORR R15 register
    run_instr(2'b00, 6'b000011, 4'd5);   // unsupported command with S
    run_instr(2'b01, 6'b011001, 4'hF);   // LDR R15

    // B
    plan_instr(2'b10, 6'b000000, 4'd0, 99, n);
    repeat (2) @(posedge clk);
    #2;
    pin("b_pcs", {1'b0, pcs}, 2'b01);
    @(posedge clk); #1;

    run_instr(2'b11, 6'b000000, 4'd0);   // illegal op class
`ifdef CTRL_ILLEGAL_TRAP_EN
    pin("trap_illegal", {1'b0, illegal}, 2'b01);
    reset = 1'b0;
    exp_q.push_back(reset_row());
    @(posedge clk); #1;
    reset = 1'b1;
`endif
    run_instr(2'b00, 6'b001001, 4'd6);   // ADDS register

    // Reset during the LDR read cycle
    plan_instr(2'b01, 6'b011001, 4'd7, 3, n);
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    exp_q.push_back(reset_row());
    #1;
    pin("midrst_adrsrc", {1'b0, adr_src}, 2'b00);
    pin("midrst_regw", {1'b0, reg_w}, 2'b00);
    pin("midrst_irwrite", {1'b0, ir_write}, 2'b00);
    @(posedge clk); #1;
    reset = 1'b1;
    run_instr(2'b10, 6'b000000, 4'd0);
    run_instr(2'b01, 6'b011000, 4'd7);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
